clk_div_checker: RTL and testbench

- Receive-side counterpart to the on-chip clock divider outputs.
- Takes one externally looped-back divided clock on sig_in (e.g. clk_div2..clk_div16 routed off-chip and back through ui_in).
- Measures its period in clk cycles and compares it against a selected expected ratio. Reports lock, mismatch errors and timeouts.
- Instantiated beside the divider inside the tt_um wrapper; outputs are mapped onto spare uo_out/uio_out pins.

---
 rtl/clk_div_checker.sv | 213 +++++++++++++++++++++
 tb/tb_clk_div_checker.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_checker.sv
// Receive-side checker for a looped-back divided clock: measures its rising-to-rising period,
// compares it against 2<<exp_sel and reports lock, errors and timeouts.
// Optional high-phase check is enabled by defining CLK_DIV_CHECKER_DUTY_CHECK_EN.
module clk_div_checker #(
   parameter int CNT_W       = 8,
   parameter int LOCK_COUNT  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   input  logic [1:0]       exp_sel,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             err,
   output logic [7:0]       err_count
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
   ,
   output logic [CNT_W-1:0] high_time
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_EDGE,
      S_MEASURE
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced_d_q;
   logic [1:0]             exp_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [3:0]             run_q, run_d;
   logic                   locked_q, locked_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic                   pv_q, pv_d;
   logic                   err_q, err_d;
   logic [7:0]             errcnt_q, errcnt_d;

   logic                   synced;
   logic                   rise;
   logic                   exp_chg;
   logic                   period_ok;
   logic                   bump_err;
   logic [CNT_W-1:0]       exp_period;

   assign synced     = sync_q[SYNC_STAGES-1];
   assign rise       = synced & ~synced_d_q;
   assign exp_chg    = (exp_sel != exp_q);
   assign exp_period = CNT_W'(2) << exp_q;

`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
   logic             fall;
   logic [CNT_W-1:0] hi_cnt_q;
   logic [CNT_W-1:0] hi_meas_q;
   logic [CNT_W-1:0] high_q, high_d;

   assign fall      = ~synced & synced_d_q;
   assign period_ok = (cnt_q == exp_period) && (hi_meas_q == (exp_period >> 1));

   // High phase counted in the synchronised domain; the last completed one is held for the compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_cnt_q  <= '0;
         hi_meas_q <= '0;
         high_q    <= '0;
      end else begin
         if (rise) begin
            hi_cnt_q <= CNT_ONE;
         end else if (synced && hi_cnt_q != CNT_MAX) begin
            hi_cnt_q <= hi_cnt_q + CNT_ONE;
         end
         if (fall) begin
            hi_meas_q <= hi_cnt_q;
         end
         high_q <= high_d;
      end
   end

   assign high_d    = pv_d ? hi_meas_q : high_q;
   assign high_time = high_q;
`else
   assign period_ok = (cnt_q == exp_period);
`endif

   // NOTE: every register is cleared asynchronously and updated with non-blocking assignments;
   // the synchroniser is reset too so no stale level produces a false edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         synced_d_q <= 1'b0;
         exp_q      <= 2'd0;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         run_q      <= 4'd0;
         locked_q   <= 1'b0;
         period_q   <= '0;
         pv_q       <= 1'b0;
         err_q      <= 1'b0;
         errcnt_q   <= 8'd0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
         synced_d_q <= synced;
         exp_q      <= exp_sel;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         run_q      <= run_d;
         locked_q   <= locked_d;
         period_q   <= period_d;
         pv_q       <= pv_d;
         err_q      <= err_d;
         errcnt_q   <= errcnt_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch;
   // blocking assignments let the later override blocks see and replace earlier decisions.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      locked_d = locked_q;
      period_d = period_q;
      pv_d     = 1'b0;
      bump_err = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d    = '0;
            run_d    = 4'd0;
            locked_d = 1'b0;
            if (en) begin
               state_d = S_WAIT_EDGE;
            end
         end
         S_WAIT_EDGE: begin
            if (rise) begin
               state_d = S_MEASURE;
               cnt_d   = CNT_ONE;
            end
         end
         S_MEASURE: begin
            if (rise) begin
               // An edge on the last count still closes a valid period.
               period_d = cnt_q;
               pv_d     = 1'b1;
               cnt_d    = CNT_ONE;
               if (period_ok) begin
                  if (run_q != LOCK_N) begin
                     run_d = run_q + 4'd1;
                  end
                  if (run_d == LOCK_N) begin
                     locked_d = 1'b1;
                  end
               end else begin
                  bump_err = 1'b1;
                  run_d    = 4'd0;
                  locked_d = 1'b0;
               end
            end else if (cnt_q == CNT_MAX) begin
               bump_err = 1'b1;
               run_d    = 4'd0;
               locked_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_WAIT_EDGE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A new expected ratio restarts the measurement silently.
      if (state_q != S_IDLE && exp_chg) begin
         state_d  = S_WAIT_EDGE;
         cnt_d    = '0;
         run_d    = 4'd0;
         locked_d = 1'b0;
         period_d = period_q;
         pv_d     = 1'b0;
         bump_err = 1'b0;
      end

      if (!en) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         run_d    = 4'd0;
         locked_d = 1'b0;
         period_d = period_q;
         pv_d     = 1'b0;
         bump_err = 1'b0;
      end

      err_d    = bump_err;
      errcnt_d = (bump_err && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
   end

   assign period       = period_q;
   assign period_valid = pv_q;
   assign locked       = locked_q;
   assign err          = err_q;
   assign err_count    = errcnt_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// Randomised bench for clk_div_checker: a rising-edge timeline model predicts every
// period_valid / err event, and lock state is checked every cycle.
`timescale 1ns/1ps
module tb_clk_div_checker;

   localparam int CNT_W      = 8;
   localparam int LOCK_COUNT = 4;
   localparam int MAX_CNT    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             sig_in;
   logic [1:0]       exp_sel;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             err;
   logic [7:0]       err_count;
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
   logic [CNT_W-1:0] high_time;
`endif

   always #5 clk = ~clk;

   clk_div_checker #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .sig_in       (sig_in),
      .exp_sel      (exp_sel),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .err          (err),
      .err_count    (err_count)
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
      ,
      .high_time    (high_time)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: works on the timeline of rising edges driven onto sig_in.
   typedef struct {
      bit tmo;
      int per;
      int hi;
      bit e;
      bit lk;
      int errs;
   } ev_t;

   ev_t evq[$];
   int  now_t = 0;
   int  last_rise = 0;
   int  rise_t = 0;
   int  m_high = 0;
   int  m_run = 0;
   int  m_errs = 0;
   int  m_period = 0;
   int  cur_exp = 0;
   bit  lr_valid = 1'b0;
   bit  m_en = 1'b0;
   bit  m_locked = 1'b0;
   bit  exp_locked_now = 1'b0;

   task automatic clear_run();
      lr_valid       = 1'b0;
      m_run          = 0;
      m_locked       = 1'b0;
      exp_locked_now = 1'b0;
   endtask

   task automatic model_edge();
      ev_t ev;
      int  p;
      int  e;
      bit  ok;
      if (lr_valid) begin
         p  = now_t - last_rise;
         e  = 2 << cur_exp;
         ok = (p == e);
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
         ok = ok && (m_high == e / 2);
`endif
         if (ok) begin
            if (m_run < LOCK_COUNT) m_run++;
            if (m_run == LOCK_COUNT) m_locked = 1'b1;
         end else begin
            m_run    = 0;
            m_locked = 1'b0;
            if (m_errs < 255) m_errs++;
         end
         m_period = p;
         ev.tmo  = 1'b0;
         ev.per  = p;
         ev.hi   = m_high;
         ev.e    = !ok;
         ev.lk   = m_locked;
         ev.errs = m_errs;
         evq.push_back(ev);
      end
      last_rise = now_t;
      lr_valid  = 1'b1;
   endtask

   // One clock of stimulus: drive at the falling edge and advance the model timeline.
   task automatic tick(input bit s, input bit e, input logic [1:0] x);
      ev_t ev;
      @(negedge clk);
      now_t++;
      if (!e && en) begin
         m_en = 1'b0;
         clear_run();
      end else if (e && !en) begin
         m_en     = 1'b1;
         lr_valid = 1'b0;
      end
      if (x != exp_sel && en && e) clear_run();
      cur_exp = x;
      en      = e;
      exp_sel = x;
      if (m_en && lr_valid && (now_t - last_rise) > MAX_CNT) begin
         m_run    = 0;
         m_locked = 1'b0;
         lr_valid = 1'b0;
         if (m_errs < 255) m_errs++;
         ev.tmo  = 1'b1;
         ev.per  = m_period;
         ev.hi   = 0;
         ev.e    = 1'b1;
         ev.lk   = 1'b0;
         ev.errs = m_errs;
         evq.push_back(ev);
      end
      if (s && !sig_in) begin
         if (m_en) model_edge();
         rise_t = now_t;
      end
      if (!s && sig_in) m_high = now_t - rise_t;
      sig_in = s;
   endtask

   task automatic sig(input bit s);
      tick(s, en, exp_sel);
   endtask

   task automatic set_ctrl(input bit e, input logic [1:0] x);
      tick(sig_in, e, x);
   endtask

   task automatic hold_low(input int n);
      repeat (n) sig(1'b0);
   endtask

   task automatic wave(input int per, input int hi, input int n);
      repeat (n) begin
         repeat (hi) sig(1'b1);
         repeat (per - hi) sig(1'b0);
      end
   endtask

   task automatic gap_edge(input int g);
      sig(1'b1);
      repeat (g - 1) sig(1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      evq.delete();
      clear_run();
      m_errs   = 0;
      m_period = 0;
      m_high   = 0;
      #1;
      check("rst_period", period, 0);
      check("rst_err_count", err_count, 0);
      check("rst_locked", locked, 0);
      check("rst_period_valid", period_valid, 0);
      check("rst_err", err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Event monitor, sampling one time unit after each rising clock edge.
   initial begin
      ev_t ev;
      forever begin
         @(posedge clk);
         #1;
         if (period_valid || err) begin
            if (evq.size() == 0) begin
               check("unexpected_event", {30'd0, period_valid, err}, 0);
            end else begin
               ev = evq.pop_front();
               check("ev_period_valid", period_valid, !ev.tmo);
               check("ev_err", err, ev.e);
               check("ev_period", period, ev.per);
               check("ev_locked", locked, ev.lk);
               check("ev_err_count", err_count, ev.errs);
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
               if (!ev.tmo) check("ev_high_time", high_time, ev.hi);
`endif
               exp_locked_now = ev.lk;
            end
         end else begin
            check("locked_steady", locked, exp_locked_now);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached with %0d events pending", evq.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n   = 1'b1;
      en      = 1'b0;
      sig_in  = 1'b0;
      exp_sel = 2'd0;
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_period", period, 0);
      check("reset_period_valid", period_valid, 0);
      check("reset_locked", locked, 0);
      check("reset_err", err, 0);
      check("reset_err_count", err_count, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hold_low(3);

      // Period-4 wave at ratio 4: lock on the fourth period.
      set_ctrl(1'b1, 2'd1);
      wave(4, 2, 8);
      hold_low(6);
      check("p4_locked", locked, 1);
      check("p4_err_count", err_count, 0);

      // Lock at ratio 8, inject one period of 6, relock.
      set_ctrl(1'b1, 2'd2);
      wave(8, 4, 6);
      wave(6, 3, 1);
      wave(8, 4, 6);
      hold_low(6);
      check("inject_err_count", err_count, 1);
      check("inject_relocked", locked, 1);

      // Counter boundary: 255 is a real period, 256 is a timeout, then a silent line times out.
      set_ctrl(1'b1, 2'd0);
      gap_edge(255);
      gap_edge(256);
      gap_edge(2);
      gap_edge(2);
      hold_low(300);
      check("tmo_period_held", period, 2);
      check("tmo_err_count", err_count, 4);
      check("tmo_locked", locked, 0);

      // Ratio change while locked drops lock without an error.
      set_ctrl(1'b1, 2'd3);
      wave(16, 8, 6);
      check("p16_locked", locked, 1);
      set_ctrl(1'b1, 2'd1);
      @(posedge clk);
      #2;
      check("exp_chg_unlocked", locked, 0);
      check("exp_chg_no_err", err, 0);
      wave(4, 2, 5);
      hold_low(6);
      check("exp_chg_relocked", locked, 1);
      check("exp_chg_err_count", err_count, 4);

      // Error counter saturation, then disable.
      set_ctrl(1'b1, 2'd0);
      wave(3, 1, 300);
      hold_low(6);
      set_ctrl(1'b0, 2'd0);
      hold_low(2);
      check("sat_err_count", err_count, 255);
      check("disabled_locked", locked, 0);

      // Reset in the middle of operation, then two edges are needed again.
      set_ctrl(1'b1, 2'd1);
      wave(4, 2, 3);
      hold_low(6);
      do_reset();
      hold_low(2);
      wave(4, 2, 6);
      hold_low(6);
      check("post_reset_locked", locked, 1);
      check("post_reset_err_count", err_count, 0);

      // Random bursts around the expected ratio.
      for (int b = 0; b < 40; b++) begin
         int e_sel;
         int per;
         int hi;
         int n;
         if ($urandom_range(0, 3) == 0) begin
            hold_low(6);
            set_ctrl(1'b1, 2'($urandom_range(0, 3)));
         end
         e_sel = int'(exp_sel);
         per   = ($urandom_range(0, 3) != 0) ? (2 << e_sel) : int'($urandom_range(2, 20));
         hi    = ($urandom_range(0, 1) == 1) ? per / 2 : int'($urandom_range(1, per - 1));
         n     = $urandom_range(2, 8);
         wave(per, hi, n);
         if ($urandom_range(0, 7) == 0) begin
            hold_low(6);
            set_ctrl(1'b0, exp_sel);
            hold_low(3);
            set_ctrl(1'b1, exp_sel);
         end
      end

      // 1-high/3-low wave at ratio 4.
      hold_low(6);
      set_ctrl(1'b1, 2'd2);
      hold_low(2);
      set_ctrl(1'b1, 2'd1);
      wave(4, 1, 6);
      hold_low(6);
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
      check("duty_never_locked", locked, 0);
      check("duty_high_time", high_time, 1);
`else
      check("no_duty_locked", locked, 1);
`endif
      check("duty_period", period, 4);

      hold_low(10);
      check("events_drained", evq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
